// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, Status/Cause bit layout
// and reset/vector defaults for cp0_exc_ctrl and cp0_timer.
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;
  localparam logic [2:0] SEL0         = 3'd0;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int ST_IE       = 0;
  localparam int ST_EXL      = 1;
  localparam int ST_IM_LO    = 8;
  localparam int ST_IM_HI    = 15;
  localparam int CA_BD       = 31;
  localparam int CA_TI       = 30;
  localparam int CA_IV       = 23;
  localparam int CA_IP_LO    = 8;
  localparam int CA_EXC_LO   = 2;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;
  localparam logic [31:0] STATUS_RST_DEF = 32'h00400000;
  localparam logic [31:0] PRID_VAL       = 32'h00004220;
  localparam logic [31:0] CONFIG_VAL     = 32'h80000000;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled Count, Compare register and the sticky TI flag.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic        ti_clr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam logic [1:0] DIV_MAX = 2'(COUNT_DIV - 1);

  logic [1:0]  div;
  logic        inc;
  logic [31:0] count_nxt;

  assign inc       = (div == DIV_MAX);
  assign count_nxt = count + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        div   <= '0;
      end else if (inc) begin
        count <= count_nxt;
        div   <= '0;
      end else begin
        div   <= div + 2'd1;
      end
      if (compare_we)
        compare <= wdata;
      // a Compare write in the same cycle as a match must leave TI clear
      if (ti_clr)
        ti <= 1'b0;
      else if (!count_we && inc && (count_nxt == compare))
        ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 register file with exception/ERET commit, timer and interrupt request.
// Optional macro CP0_CFG_REGS_EN adds read-only PRId (15,0) and Config (16,0).
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          HW_INT_NUM = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [31:0] STATUS_RST = STATUS_RST_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [2:0]            wsel,
  input  logic [31:0]           wdata,
  input  logic [4:0]            raddr,
  input  logic [2:0]            rsel,
  output logic [31:0]           rdata,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  output logic                  int_req,
  output logic                  flush,
  output logic [31:0]           flush_pc,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  logic [31:0] status, epc, badvaddr, count, compare, cause, rd_next;
  logic        cause_bd, cause_iv, ti;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw, hw6;
  logic [4:0]  cause_exc;
  logic [7:0]  cause_ip;
  logic        wr_en, count_we, compare_we;

  always_comb begin
    hw6                 = '0;
    hw6[HW_INT_NUM-1:0] = hw_int;
  end

  // mtc0 only lands when no exception or ERET commits this cycle
  assign wr_en      = we && !exc_valid && !eret && (wsel == SEL0);
  assign count_we   = wr_en && (waddr == REG_COUNT);
  assign compare_we = wr_en && (waddr == REG_COMPARE);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .count_we  (count_we),
    .compare_we(compare_we),
    .ti_clr    (compare_we),
    .wdata     (wdata),
    .count     (count),
    .compare   (compare),
    .ti        (ti)
  );

  assign cause_ip = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign cause    = {cause_bd, ti, 6'b0, cause_iv, 7'b0, cause_ip, 1'b0, cause_exc, 2'b0};
  assign int_req  = status[ST_IE] && !status[ST_EXL] &&
                    (|(status[ST_IM_HI:ST_IM_LO] & cause_ip));
  assign flush    = exc_valid || eret;
  assign flush_pc = exc_valid ? EXC_VECTOR : epc;
  assign status_o = status;
  assign cause_o  = cause;
  assign epc_o    = epc;

  always_comb begin
    rd_next = '0;
    if (rsel == SEL0) begin
      case (raddr)
        REG_BADVADDR: rd_next = badvaddr;
        REG_COUNT:    rd_next = count;
        REG_COMPARE:  rd_next = compare;
        REG_STATUS:   rd_next = status;
        REG_CAUSE:    rd_next = cause;
        REG_EPC:      rd_next = epc;
`ifdef CP0_CFG_REGS_EN
        REG_PRID:     rd_next = PRID_VAL;
        REG_CONFIG:   rd_next = CONFIG_VAL;
`endif
        default:      rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status    <= STATUS_RST;
      epc       <= '0;
      badvaddr  <= '0;
      cause_bd  <= 1'b0;
      cause_iv  <= 1'b0;
      cause_exc <= '0;
      ip_sw     <= '0;
      ip_hw     <= '0;
      rdata     <= '0;
    end else begin
      ip_hw <= hw6;
      rdata <= rd_next;
      if (exc_valid) begin
        // nested exceptions keep the original EPC/BD
        if (!status[ST_EXL]) begin
          epc      <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
          cause_bd <= exc_bd;
        end
        cause_exc       <= exc_code;
        status[ST_EXL]  <= 1'b1;
        if (exc_code == 5'(EXC_ADEL) || exc_code == 5'(EXC_ADES))
          badvaddr <= exc_badvaddr;
      end else if (eret) begin
        status[ST_EXL] <= 1'b0;
      end else if (wr_en) begin
        case (waddr)
          REG_STATUS: status <= wdata;
          REG_CAUSE: begin
            ip_sw    <= wdata[CA_IP_LO+1:CA_IP_LO];
            cause_iv <= wdata[CA_IV];
          end
          REG_EPC:   epc <= wdata;
          default: ;
        endcase
      end
    end
  end

endmodule
